supersonic_ranger: RTL and testbench
====================================

Name: supersonic_ranger

Overview:
- Initiator side of the ultrasonic ranging interface. Drives the sensor's trigger pin with a timed pulse.
- Watches the echo receiver's status strobes: echo started, measurement valid, receiver timeout.
- Enforces the 50 ms inter-measurement spacing that prevents interference.
- Retries failed attempts and supports single-shot or continuous ranging. Sits between the application FSM and the echo receiver; clock is 50 MHz (20 ns).

Parameters:
- TRIG_CYC, 550: trigger high time in cycles (11 us, above the 10 us minimum).
- ECHO_WAIT_CYC, 50000: max cycles after trigger falls for echo to start (1 ms).
- GAP_CYC, 2500000: quiet cycles after every attempt (50 ms).
- CNT_W, 22: width of the shared timer; must hold max(TRIG_CYC, ECHO_WAIT_CYC, GAP_CYC).
- MAX_RETRY, 3: failed attempts allowed per request before err.
- RW, 2: width of attempt counter; must hold MAX_RETRY.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request one measurement. Sampled only in IDLE.
- continuous  in  1  when high, re-arm automatically after every gap.
- echo_start  in  1  1-cycle strobe from receiver: echo rose.
- echo_done  in  1  1-cycle strobe from receiver: measurement valid.
- echo_fail  in  1  1-cycle strobe from receiver: echo too long / timeout.
- trigger  out  1  to sensor trigger pin. Registered.
- busy  out  1  high whenever state != IDLE.
- done  out  1  1-cycle pulse: measurement succeeded.
- err  out  1  1-cycle pulse: MAX_RETRY consecutive failures.
- attempt  out  RW  failed attempts in the current request.

Behaviour:
- Reset (synchronous, rst high at posedge): state=IDLE, timer=0. trigger, busy, done, err and attempt are all 0 from the next cycle. This applies mid-operation too: trigger drops on the next edge.
- All outputs are registered.
- Single timer cnt (CNT_W bits) is cleared on every state change. It saturates, never wraps.
- IDLE:
  - start or continuous -> TRIG (cnt=0, trigger=1 from the next cycle).
  - Both low -> stay.
- TRIG:
  - trigger=1; cnt increments.
  - At cnt==TRIG_CYC-1 -> WAIT_ECHO, trigger=0. Trigger is high exactly TRIG_CYC cycles.
  - Receiver strobes are ignored in this state.
- WAIT_ECHO:
  - echo_start -> MEASURE.
  - Else at cnt==ECHO_WAIT_CYC-1 -> failed attempt.
  - echo_start on the timeout cycle wins, i.e. counts as no failure.
- MEASURE:
  - echo_done -> done=1 for one cycle, attempt=0, -> GAP.
  - echo_fail -> failed attempt.
  - echo_done and echo_fail in the same cycle: done wins.
  - No local timeout; the receiver's fail strobe bounds this state.
- Failed attempt:
  - attempt+1. If the new value == MAX_RETRY: err=1 for one cycle, attempt=0, clear the retry-pending flag.
  - Otherwise set the retry-pending flag.
  - Either way -> GAP.
- GAP:
  - trigger=0; cnt counts to GAP_CYC-1.
  - At end: retry-pending or continuous -> TRIG (clear retry-pending). Else -> IDLE.
- start outside IDLE is ignored, not queued.
- continuous falling mid-sequence: the current attempt and its retries complete, then IDLE.
- echo_start/echo_done/echo_fail outside their consuming state are ignored.
- Latency:
  - start sampled at edge N -> trigger high from edge N+1.
  - echo_done at edge M -> done high at M+1.
- done and err never assert in the same cycle. busy is high while done/err are asserted.
- Pulse spacing guarantee: consecutive trigger rising edges are at least TRIG_CYC+GAP_CYC+1 cycles apart.

Test Plan (TRIG_CYC=5, ECHO_WAIT_CYC=20, GAP_CYC=10, MAX_RETRY=2, RW=2):
1. start pulse at cycle 0, echo_start at 10, echo_done at 30 -> trigger high cycles 1-5, done=1 at cycle 31 only, busy drops at cycle 41, attempt stays 0.
2. start, no echo ever -> two trigger pulses spaced by 5+20+10 cycles. attempt reads 1 during the first gap. err=1 for one cycle at the end of the second wait. Returns to IDLE after the final gap. done never asserts.
3. continuous=1 held, echo_done each attempt -> periodic trigger pulses. done once per attempt. Deassert continuous during a MEASURE -> that done still fires, then IDLE after the gap.
4. echo_start on the exact timeout cycle, and echo_done together with echo_fail -> no failure recorded, done=1, attempt=0.
5. rst pulsed mid-TRIG and mid-GAP -> trigger=0 and busy=0 the next cycle. start immediately afterwards produces a full TRIG_CYC-wide pulse.
6. start pulses while busy, and stray echo_done in IDLE/TRIG -> no state change, no done pulse.

Source files
------------

// File: rtl/supersonic_ranger.sv
// Ultrasonic ranging initiator: times the sensor trigger pulse, tracks the echo receiver
// strobes, retries failed attempts and enforces the quiet gap between attempts.
module supersonic_ranger #(
    parameter int unsigned TRIG_CYC      = 550,
    parameter int unsigned ECHO_WAIT_CYC = 50000,
    parameter int unsigned GAP_CYC       = 2500000,
    parameter int unsigned CNT_W         = 22,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned RW            = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          continuous,
    input  logic          echo_start,
    input  logic          echo_done,
    input  logic          echo_fail,
    output logic          trigger,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [RW-1:0] attempt,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_MEAS = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(ECHO_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [RW:0]      RETRY_LIMIT = (RW + 1)'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    attempt_q, attempt_d;
    logic [RW:0]      attempt_inc;
    logic             retry_q, retry_d;
    logic             trigger_q, trigger_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fail_now, success_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            attempt_q <= '0;
            retry_q   <= 1'b0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            attempt_q <= attempt_d;
            retry_q   <= retry_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Receiver strobes only matter in the state that consumes them; done beats fail.
    always_comb begin
        state_d     = state_q;
        fail_now    = 1'b0;
        success_now = 1'b0;
        unique case (state_q)
            S_IDLE: if (start || continuous) state_d = S_TRIG;
            S_TRIG: if (cnt_q == TRIG_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (echo_start) begin
                    state_d = S_MEAS;
                end else if (cnt_q == WAIT_LAST) begin
                    fail_now = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_MEAS: begin
                if (echo_done) begin
                    success_now = 1'b1;
                    state_d     = S_GAP;
                end else if (echo_fail) begin
                    fail_now = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_GAP: if (cnt_q == GAP_LAST) state_d = (retry_q || continuous) ? S_TRIG : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        attempt_inc = {1'b0, attempt_q} + (RW + 1)'(1);
        attempt_d   = attempt_q;
        retry_d     = retry_q;
        err_d       = 1'b0;
        if (success_now) begin
            attempt_d = '0;
        end else if (fail_now) begin
            if (attempt_inc == RETRY_LIMIT) begin
                err_d     = 1'b1;
                attempt_d = '0;
                retry_d   = 1'b0;
            end else begin
                attempt_d = attempt_inc[RW-1:0];
                retry_d   = 1'b1;
            end
        end
        if (state_q == S_GAP && state_d == S_TRIG) retry_d = 1'b0;
        done_d    = success_now;
        trigger_d = (state_d == S_TRIG);
        busy_d    = (state_d != S_IDLE);
    end

    assign trigger   = trigger_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign attempt   = attempt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_supersonic_ranger.sv
// Directed bench for supersonic_ranger: trigger/done/err events are scored against an
// expected queue, and per-cycle outputs are checked at the interesting boundaries.
module tb_supersonic_ranger;

    localparam int TRIG_CYC      = 5;
    localparam int ECHO_WAIT_CYC = 20;
    localparam int GAP_CYC       = 10;
    localparam int CNT_W         = 8;
    localparam int MAX_RETRY     = 2;
    localparam int RW            = 2;

    localparam logic [7:0] EV_TRIG = 8'd1;
    localparam logic [7:0] EV_DONE = 8'd2;
    localparam logic [7:0] EV_ERR  = 8'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TRIG = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_MEAS = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    logic          clk = 1'b0;
    logic          rst, start, continuous, echo_start, echo_done, echo_fail;
    logic          trigger, busy, done, err;
    logic [RW-1:0] attempt;
    logic [2:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int g        = 0;
    int lc       = 0;
    int base     = 0;
    logic [31:0] exp_q[$];
    logic trig_prev = 1'b0;

    supersonic_ranger #(
        .TRIG_CYC      (TRIG_CYC),
        .ECHO_WAIT_CYC (ECHO_WAIT_CYC),
        .GAP_CYC       (GAP_CYC),
        .CNT_W         (CNT_W),
        .MAX_RETRY     (MAX_RETRY),
        .RW            (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .echo_start (echo_start),
        .echo_done  (echo_done),
        .echo_fail  (echo_fail),
        .trigger    (trigger),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .attempt    (attempt),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) g <= g + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input logic [7:0] ty, input int k);
        exp_q.push_back({ty, 24'(base + k)});
    endtask

    task automatic note_event(input logic [7:0] ty);
        logic [31:0] ev;
        ev = {ty, 24'(g)};
        if (exp_q.size() == 0) chk("event_unexpected", ev, 32'h0);
        else chk("event_order", ev, exp_q.pop_front());
    endtask

    // Event monitor, sampled mid-cycle; g identifies the cycle the event appeared in.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (trigger === 1'b1 && trig_prev === 1'b0) note_event(EV_TRIG);
            if (done === 1'b1) note_event(EV_DONE);
            if (err === 1'b1) note_event(EV_ERR);
        end
        trig_prev <= trigger;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lc++;
        start      = 1'b0;
        echo_start = 1'b0;
        echo_done  = 1'b0;
        echo_fail  = 1'b0;
    endtask

    task automatic idle_to(input int k);
        while (lc < k) tick();
    endtask

    task automatic begin_scn();
        lc   = 0;
        base = g;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        echo_start = 1'b0;
        echo_done  = 1'b0;
        echo_fail  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trigger", trigger, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_attempt", attempt, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();

        // Single successful measurement
        begin_scn();
        expect_ev(EV_TRIG, 1);
        expect_ev(EV_DONE, 31);
        start = 1'b1;
        tick();
        chk("s1_trig_c1", trigger, 1);
        chk("s1_busy_c1", busy, 1);
        idle_to(5);  chk("s1_trig_c5", trigger, 1);
        idle_to(6);  chk("s1_trig_c6", trigger, 0);
        chk("s1_state_c6", dbg_state, ST_WAIT);
        idle_to(10); echo_start = 1'b1; tick();
        chk("s1_state_c11", dbg_state, ST_MEAS);
        idle_to(30); echo_done = 1'b1; tick();
        chk("s1_done_c31", done, 1);
        chk("s1_busy_c31", busy, 1);
        chk("s1_attempt_c31", attempt, 0);
        idle_to(32); chk("s1_done_c32", done, 0);
        idle_to(40); chk("s1_busy_c40", busy, 1);
        idle_to(41); chk("s1_busy_c41", busy, 0);

        // No echo ever: one retry, then err
        begin_scn();
        expect_ev(EV_TRIG, 1);
        expect_ev(EV_TRIG, 36);
        expect_ev(EV_ERR, 61);
        start = 1'b1;
        tick();
        idle_to(25); chk("s2_attempt_c25", attempt, 0);
        idle_to(26); chk("s2_attempt_c26", attempt, 1);
        chk("s2_state_c26", dbg_state, ST_GAP);
        idle_to(35); chk("s2_trig_c35", trigger, 0);
        idle_to(36); chk("s2_trig_c36", trigger, 1);
        idle_to(60); chk("s2_err_c60", err, 0);
        chk("s2_attempt_c60", attempt, 1);
        idle_to(61); chk("s2_err_c61", err, 1);
        chk("s2_attempt_c61", attempt, 0);
        chk("s2_done_c61", done, 0);
        chk("s2_busy_c61", busy, 1);
        idle_to(62); chk("s2_err_c62", err, 0);
        idle_to(70); chk("s2_busy_c70", busy, 1);
        idle_to(71); chk("s2_busy_c71", busy, 0);
        chk("s2_state_c71", dbg_state, ST_IDLE);

        // Continuous ranging, dropped during the third MEASURE
        begin_scn();
        expect_ev(EV_TRIG, 1);
        expect_ev(EV_DONE, 13);
        expect_ev(EV_TRIG, 23);
        expect_ev(EV_DONE, 35);
        expect_ev(EV_TRIG, 45);
        expect_ev(EV_DONE, 57);
        continuous = 1'b1;
        tick();
        idle_to(8);  echo_start = 1'b1; tick();
        idle_to(12); echo_done = 1'b1; tick();
        chk("s3_done_c13", done, 1);
        idle_to(22); chk("s3_trig_c22", trigger, 0);
        idle_to(23); chk("s3_trig_c23", trigger, 1);
        chk("s3_attempt_c23", attempt, 0);
        idle_to(30); echo_start = 1'b1; tick();
        idle_to(34); echo_done = 1'b1; tick();
        idle_to(52); echo_start = 1'b1; tick();
        chk("s3_state_c53", dbg_state, ST_MEAS);
        idle_to(54); continuous = 1'b0;
        idle_to(56); echo_done = 1'b1; tick();
        chk("s3_done_c57", done, 1);
        idle_to(66); chk("s3_busy_c66", busy, 1);
        idle_to(67); chk("s3_busy_c67", busy, 0);
        idle_to(75); chk("s3_state_c75", dbg_state, ST_IDLE);

        // Failed attempt, then echo on the exact timeout cycle and done+fail together
        begin_scn();
        expect_ev(EV_TRIG, 1);
        expect_ev(EV_TRIG, 23);
        expect_ev(EV_DONE, 51);
        start = 1'b1;
        tick();
        idle_to(8);  echo_start = 1'b1; tick();
        idle_to(12); echo_fail = 1'b1; tick();
        chk("s4_attempt_c13", attempt, 1);
        chk("s4_err_c13", err, 0);
        idle_to(47); echo_start = 1'b1; tick();
        chk("s4_state_c48", dbg_state, ST_MEAS);
        chk("s4_attempt_c48", attempt, 1);
        idle_to(50); echo_done = 1'b1; echo_fail = 1'b1; tick();
        chk("s4_done_c51", done, 1);
        chk("s4_err_c51", err, 0);
        chk("s4_attempt_c51", attempt, 0);
        idle_to(61); chk("s4_busy_c61", busy, 0);

        // Reset mid-TRIG and mid-GAP
        begin_scn();
        expect_ev(EV_TRIG, 1);
        expect_ev(EV_TRIG, 5);
        expect_ev(EV_TRIG, 41);
        expect_ev(EV_DONE, 53);
        start = 1'b1;
        tick();
        idle_to(3); rst = 1'b1; tick();
        chk("s5_trig_after_rst1", trigger, 0);
        chk("s5_busy_after_rst1", busy, 0);
        rst = 1'b0; start = 1'b1; tick();
        chk("s5_trig_c5", trigger, 1);
        idle_to(9);  chk("s5_trig_c9", trigger, 1);
        idle_to(10); chk("s5_trig_c10", trigger, 0);
        idle_to(30); chk("s5_attempt_c30", attempt, 1);
        idle_to(33); rst = 1'b1; tick();
        chk("s5_trig_after_rst2", trigger, 0);
        chk("s5_busy_after_rst2", busy, 0);
        chk("s5_attempt_after_rst2", attempt, 0);
        rst = 1'b0;
        idle_to(40); chk("s5_busy_c40", busy, 0);
        start = 1'b1; tick();
        idle_to(45); chk("s5_trig_c45", trigger, 1);
        idle_to(46); chk("s5_trig_c46", trigger, 0);
        idle_to(50); echo_start = 1'b1; tick();
        idle_to(52); echo_done = 1'b1; tick();
        idle_to(63); chk("s5_busy_c63", busy, 0);

        // Stray strobes and start while busy
        begin_scn();
        expect_ev(EV_TRIG, 5);
        expect_ev(EV_DONE, 17);
        echo_done = 1'b1;  tick();
        echo_start = 1'b1; tick();
        echo_fail = 1'b1;  tick();
        chk("s6_busy_c3", busy, 0);
        chk("s6_state_c3", dbg_state, ST_IDLE);
        idle_to(4); start = 1'b1; tick();
        idle_to(6); echo_done = 1'b1; tick();
        echo_start = 1'b1; start = 1'b1; tick();
        chk("s6_state_c8", dbg_state, ST_TRIG);
        idle_to(10); chk("s6_state_c10", dbg_state, ST_WAIT);
        idle_to(12); echo_start = 1'b1; tick();
        idle_to(14); start = 1'b1; tick();
        idle_to(16); echo_done = 1'b1; tick();
        idle_to(20); start = 1'b1; tick();
        idle_to(27); chk("s6_busy_c27", busy, 0);
        idle_to(30); chk("s6_trig_c30", trigger, 0);
        chk("s6_busy_c30", busy, 0);

        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
